// File: rtl/trojan6_bus_pkg.sv
// Shared types and constants for the Trojan6 round-robin bus host.
// Latency: none (declarations only).
// Backpressure: not applicable.
package trojan6_bus_pkg;

    localparam int LFSR_W    = 128;
    localparam int LFSR_TAP0 = 127;
    localparam int LFSR_TAP1 = 95;
    localparam int LFSR_TAP2 = 63;
    localparam int TXN_CNT_W = 16;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        DECODE = 3'd2,
        XFER   = 3'd3,
        DONE   = 3'd4
    } bus_state_e;

    // One Fibonacci step: shift left, feedback from the three taps into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2]};
    endfunction

endpackage

// File: rtl/Trojan6.sv
// Data-path payload block on the low 32 write-data bits.
// Latency: purely combinational.
// Backpressure: none; passes data straight through while dormant.
module Trojan6 (
    input  logic [31:0] m0_data_o,
    input  logic [31:0] i_s15_data_o,
    output logic [31:0] i_s15_data_o_TrojanPayload
);

    logic trig;

    // Fires on a fixed tag in the upper half-word; the LFSR word then scrambles the data.
    assign trig = (i_s15_data_o[31:16] == 16'hC0DE);
    assign i_s15_data_o_TrojanPayload = trig ? (i_s15_data_o ^ m0_data_o) : i_s15_data_o;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester scanning upward from ptr+1, modulo N.
// Latency: purely combinational.
// Backpressure: none; grant only when enable is high.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          enable_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] winner_o,
    output logic          any_o
);

    int   scan_idx;
    logic found;

    // Scan ptr+1 .. ptr+N and stop at the first active request.
    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 1; i <= N; i++) begin
            scan_idx = (int'(ptr_i) + i) % N;
            if (enable_i && !found && req_i[scan_idx]) begin
                found           = 1'b1;
                winner_o        = IW'(scan_idx);
                gnt_o[scan_idx] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/trojan6_rr_bus_host.sv
// Multi-master bus host: round-robin grant, range-checked slave register file, counters.
// Latency: grant 1 cycle after request sample, bus_err after 2, bus_ack after 3; 5-cycle txn period.
// Backpressure: masters hold m_req until own ack/err; others wait for the next ARB.
module trojan6_rr_bus_host
    import trojan6_bus_pkg::*;
#(
    parameter int           MASTER_COUNT = 4,
    parameter int           SLAVE_COUNT  = 6,
    parameter int           SEL_WIDTH    = 3,
    parameter int           DATA_WIDTH   = 32,
    parameter logic [127:0] BUS_PATTERN  = 128'h0123456789ABCDEF0123456789ABCDEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [MASTER_COUNT-1:0]             m_req,
    input  logic [MASTER_COUNT-1:0]             m_we,
    input  logic [MASTER_COUNT*SEL_WIDTH-1:0]   m_sel,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0]  m_wdata,
    output logic [MASTER_COUNT-1:0]             m_gnt,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                bus_ack,
    output logic                                bus_err,
    output logic [TXN_CNT_W-1:0]                txn_count,
    output logic [ERR_CNT_W-1:0]                err_count
);

    localparam int MIW = $clog2(MASTER_COUNT);

    bus_state_e                  state_q, state_d;
    logic [MASTER_COUNT-1:0]     gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic [TXN_CNT_W-1:0]        txn_q, txn_d;
    logic [ERR_CNT_W-1:0]        errc_q, errc_d;
    logic [LFSR_W-1:0]           lfsr_q, lfsr_d;
    logic [MIW-1:0]              ptr_q, ptr_d;
    logic                        we_q, we_d;
    logic [SEL_WIDTH-1:0]        sel_q, sel_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]       regs_q [0:SLAVE_COUNT-1];

    logic [MASTER_COUNT-1:0]     arb_gnt;
    logic [MIW-1:0]              arb_winner;
    logic                        arb_any;
    logic                        reg_wr;
    logic [DATA_WIDTH-1:0]       wr_word;
    logic [31:0]                 m0_data_o;
    logic [31:0]                 i_s15_data_o;
    logic [31:0]                 i_s15_data_o_TrojanPayload;

    rr_arbiter #(.N(MASTER_COUNT), .IW(MIW)) u_arb (
        .req_i    (m_req),
        .ptr_i    (ptr_q),
        .enable_i (state_q == ARB),
        .gnt_o    (arb_gnt),
        .winner_o (arb_winner),
        .any_o    (arb_any)
    );

    assign m0_data_o    = lfsr_q[31:0];
    assign i_s15_data_o = wdata_q[31:0];

    Trojan6 u_trojan6 (
        .m0_data_o                  (m0_data_o),
        .i_s15_data_o               (i_s15_data_o),
        .i_s15_data_o_TrojanPayload (i_s15_data_o_TrojanPayload)
    );

    // Stored word: upper bits bypass the payload block, low 32 bits go through it.
    always_comb begin
        wr_word       = wdata_q;
        wr_word[31:0] = i_s15_data_o_TrojanPayload;
    end

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        txn_d   = txn_q;
        errc_d  = errc_q;
        lfsr_d  = lfsr_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        reg_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_req) state_d = ARB;
            end
            ARB: begin
                // Request may have dropped between IDLE and ARB: no grant, no LFSR step.
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    we_d    = m_we[arb_winner];
                    sel_d   = m_sel[int'(arb_winner)*SEL_WIDTH +: SEL_WIDTH];
                    wdata_d = m_wdata[int'(arb_winner)*DATA_WIDTH +: DATA_WIDTH];
                    ptr_d   = arb_winner;
                    lfsr_d  = lfsr_step(lfsr_q);
                    state_d = DECODE;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                if (int'(sel_q) >= SLAVE_COUNT) begin
                    err_d   = 1'b1;
                    if (errc_q != '1) errc_d = errc_q + ERR_CNT_W'(1);
                    state_d = DONE;
                end else begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // Read-before-write: rdata captures the value prior to this write.
                rdata_d = regs_q[sel_q];
                reg_wr  = we_q;
                ack_d   = 1'b1;
                txn_d   = txn_q + TXN_CNT_W'(1);
                state_d = DONE;
            end
            DONE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            txn_q   <= '0;
            errc_q  <= '0;
            lfsr_q  <= BUS_PATTERN;
            ptr_q   <= MIW'(MASTER_COUNT - 1);
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
            errc_q  <= errc_d;
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    // Slave register file; each entry resets to the pattern plus a per-slave 4 KiB stride.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SLAVE_COUNT; k++) begin
                regs_q[k] <= DATA_WIDTH'(BUS_PATTERN[31:0] + 32'(k) * 32'h1000);
            end
        end else if (reg_wr) begin
            regs_q[sel_q] <= wr_word;
        end
    end

    assign m_gnt     = gnt_q;
    assign rdata     = rdata_q;
    assign bus_ack   = ack_q;
    assign bus_err   = err_q;
    assign txn_count = txn_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_trojan6_rr_bus_host.sv
// Self-checking bench for trojan6_rr_bus_host: vector table plus multi-cycle sequences.
// Expected outputs are queued at drive time and compared when ack/err appears.
// All waits on the DUT are cycle-bounded.
module tb_trojan6_rr_bus_host;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   m_req, m_we;
    logic [11:0]  m_sel;
    logic [127:0] m_wdata;
    logic [3:0]   m_gnt;
    logic [31:0]  rdata;
    logic         bus_ack, bus_err;
    logic [15:0]  txn_count;
    logic [7:0]   err_count;

    trojan6_rr_bus_host dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_sel     (m_sel),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .rdata     (rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .txn_count (txn_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          master;
        bit          is_err;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        int          master;
        bit          we;
        logic [2:0]  sel;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;
    int   exp_txn = 0;
    int   exp_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] lfsr_model(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[95] ^ s[63]};
    endfunction

    // Pop the oldest expectation and compare against the completion now visible.
    task automatic observe();
        sb_t        e;
        logic [3:0] g;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got ack=%b err=%b expected none", bus_ack, bus_err);
        end else begin
            e = sb_q.pop_front();
            g = 4'b0001 << e.master;
            check("grant", 64'(m_gnt), 64'(g));
            check("err_pulse", 64'(bus_err), 64'(e.is_err));
            check("ack_pulse", 64'(bus_ack), 64'(!e.is_err));
            if (!e.is_err) begin
                check("rdata", 64'(rdata), 64'(e.rdata));
                exp_txn = (exp_txn + 1) % 65536;
            end else if (exp_err < 255) begin
                exp_err++;
            end
            check("txn_count", 64'(txn_count), 64'(exp_txn));
            check("err_count", 64'(err_count), 64'(exp_err));
        end
    endtask

    task automatic wait_output(input int budget, output int edges);
        bit found;
        found = 1'b0;
        edges = 0;
        while (!found && edges < budget) begin
            @(negedge clk);
            edges++;
            if (bus_ack || bus_err) found = 1'b1;
        end
        if (found) begin
            observe();
        end else begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got no ack/err expected one within %0d cycles", budget);
        end
    endtask

    task automatic drive(input int master, input bit we, input logic [2:0] sel, input logic [31:0] wdata);
        m_we[master]              = we;
        m_sel[master*3 +: 3]      = sel;
        m_wdata[master*32 +: 32]  = wdata;
        m_req[master]             = 1'b1;
    endtask

    task automatic single_txn(input int master, input bit we, input logic [2:0] sel,
                              input logic [31:0] wdata, input bit is_err, input logic [31:0] exp_rd);
        sb_t e;
        int  edges;
        e.master = master;
        e.is_err = is_err;
        e.rdata  = exp_rd;
        sb_q.push_back(e);
        drive(master, we, sel, wdata);
        wait_output(10, edges);
        check("latency", 64'(edges), is_err ? 64'd3 : 64'd4);
        m_req[master] = 1'b0;
        @(negedge clk);
        check("pulse_one_cycle", 64'({bus_ack, bus_err}), 64'd0);
        check("grant_released", 64'(m_gnt), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_req = '0;
        sb_q.delete();
        exp_txn = 0;
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t         e;
        int          edges;
        logic [127:0] lf;
        logic [31:0]  exp_payload;

        vecs[0]  = '{0, 1'b0, 3'd3, 32'h0,        1'b0, 32'h89ABFDEF};
        vecs[1]  = '{1, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h89ABEDEF};
        vecs[2]  = '{1, 1'b0, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3]  = '{2, 1'b1, 3'd7, 32'h12345678, 1'b1, 32'h0};
        vecs[4]  = '{3, 1'b0, 3'd0, 32'h0,        1'b0, 32'h89ABCDEF};
        vecs[5]  = '{0, 1'b1, 3'd5, 32'hA5A5A5A5, 1'b0, 32'h89AC1DEF};
        vecs[6]  = '{2, 1'b0, 3'd5, 32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[7]  = '{3, 1'b0, 3'd6, 32'h0,        1'b1, 32'h0};
        vecs[8]  = '{0, 1'b1, 3'd3, 32'h11112222, 1'b0, 32'h89ABFDEF};
        vecs[9]  = '{1, 1'b0, 3'd3, 32'h0,        1'b0, 32'h11112222};
        vecs[10] = '{2, 1'b0, 3'd1, 32'h0,        1'b0, 32'h89ABDDEF};
        vecs[11] = '{3, 1'b0, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[12] = '{0, 1'b0, 3'd4, 32'h0,        1'b0, 32'h89AC0DEF};

        // Reset values
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_sel   = '0;
        m_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(m_gnt), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_pulses", 64'({bus_ack, bus_err}), 64'd0);
        check("rst_txn", 64'(txn_count), 64'd0);
        check("rst_errc", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_grant", 64'(m_gnt), 64'd0);

        // Vector table, one master at a time
        for (int i = 0; i < 13; i++) begin
            single_txn(vecs[i].master, vecs[i].we, vecs[i].sel, vecs[i].wdata,
                       vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Continuous requests from all masters: strict rotation from master 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            e.master = i % 4;
            e.is_err = 1'b0;
            e.rdata  = 32'h89ABCDEF;
            sb_q.push_back(e);
        end
        for (int m = 0; m < 4; m++) drive(m, 1'b0, 3'd0, 32'h0);
        for (int i = 0; i < 8; i++) wait_output(12, edges);
        m_req = '0;
        repeat (3) @(negedge clk);
        check("rot_txn_total", 64'(txn_count), 64'd8);

        // Decode errors and err_count saturation
        do_reset();
        drive(2, 1'b1, 3'd7, 32'h12345678);
        for (int k = 1; k <= 300; k++) begin
            e.master = 2;
            e.is_err = 1'b1;
            e.rdata  = 32'h0;
            sb_q.push_back(e);
            wait_output(10, edges);
            if (k == 1 || k == 255 || k == 256 || k == 300)
                check("sat_err_count", 64'(err_count), 64'((k < 255) ? k : 255));
        end
        m_req = '0;
        repeat (2) @(negedge clk);
        check("sat_no_txn", 64'(txn_count), 64'd0);
        single_txn(1, 1'b0, 3'd2, 32'h0, 1'b0, 32'h89ABEDEF);

        // Reset asserted while a write sits in DECODE
        do_reset();
        single_txn(1, 1'b0, 3'd0, 32'h0, 1'b0, 32'h89ABCDEF);
        drive(0, 1'b1, 3'd4, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        check("abort_gnt_decode", 64'(m_gnt), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_gnt", 64'(m_gnt), 64'd0);
        check("abort_rdata", 64'(rdata), 64'd0);
        check("abort_txn", 64'(txn_count), 64'd0);
        check("abort_pulses", 64'({bus_ack, bus_err}), 64'd0);
        m_req = '0;
        sb_q.delete();
        exp_txn = 0;
        exp_err = 0;
        @(negedge clk);
        check("abort_no_ack", 64'({bus_ack, bus_err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        single_txn(3, 1'b0, 3'd4, 32'h0, 1'b0, 32'h89AC0DEF);

        // Triggered payload: stored word is data XOR the LFSR word after one step
        do_reset();
        lf = lfsr_model(128'h0123456789ABCDEF0123456789ABCDEF);
        exp_payload = 32'hC0DE1234 ^ lf[31:0];
        single_txn(0, 1'b1, 3'd1, 32'hC0DE1234, 1'b0, 32'h89ABDDEF);
        single_txn(1, 1'b0, 3'd1, 32'h0, 1'b0, exp_payload);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
